csr_regfile: RTL and testbench
==============================

CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 Parameter HART_ID, 0, constant value returned on reads of mhartid.
REQ-002 Parameter RESET_MTVEC, 64'h0, mtvec value after reset; bits [1:0] are ignored.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 clint_we_i / clint_addr_i / clint_wdata_i  input  1/12/64  trap-controller write port: write enable, CSR address, write data.
REQ-006 ex_we_i / ex_waddr_i / ex_wdata_i  input  1/12/64  execute-stage CSR-instruction write port.
REQ-007 rd_addr_i  input  12  execute-stage read address; rd_data_o  output  64  read data, combinational.
REQ-008 instr_retire_i  input  1  one instruction retires this cycle.
REQ-009 tmr_irq_i / ext_irq_i  input  1/1  raw timer and external interrupt lines.
REQ-010 csr_mtvec_o / csr_mepc_o / csr_mstatus_o  output  64 each  current register values, driven directly from the flops.
REQ-011 glb_irqen_o  output  1  equals mstatus.MIE (bit 3).
REQ-012 tmr_irq_o / ext_irq_o  output  1/1  tmr_irq_i & mie[7]; ext_irq_i & mie[11].

Function
REQ-013 Implemented CSRs and addresses: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
REQ-014 Reads of unimplemented addresses return 64'h0; writes to them have no effect.
REQ-015 misa reads 64'h8000_0000_0000_0100 (RV64I); mhartid reads HART_ID; writes to both are ignored.
REQ-016 mstatus write mask: only bit 3 (MIE) and bit 7 (MPIE) are writable; bits [12:11] (MPP) always read 2'b11; all other bits read 0.
REQ-017 mtvec bits [1:0] and mepc bits [1:0] are forced to 0 on write (direct mode, 4-byte alignment).
REQ-018 mie: only bits 3, 7 and 11 are writable; all other bits read 0.
REQ-019 mip is read-only: bit 7 = registered tmr_irq_i, bit 11 = registered ext_irq_i, one cycle of latency; all other bits 0.
REQ-020 mscratch and mcause: full 64-bit read/write.
REQ-021 A write takes effect at the rising edge following the cycle in which the write enable is sampled high; the written value is visible on rd_data_o and on the *_o taps from the next cycle.
REQ-022 Simultaneous writes from both ports: the clint port wins; the ex write is discarded entirely, even when the two addresses differ.
REQ-023 Read bypass: when ex_we_i=1, clint_we_i=0 and ex_waddr_i==rd_addr_i, rd_data_o returns the masked ex_wdata_i in the same cycle.
REQ-024 mcycle increments by 1 every cycle and wraps from 2^64-1 to 0; a write in a given cycle loads the written value, with no increment that cycle.
REQ-025 minstret increments by 1 in each cycle where instr_retire_i=1 and wraps from 2^64-1 to 0; a write has priority over the increment.
REQ-026 The clint port accepts a write every cycle, for example back-to-back mepc, mcause, mstatus; there is no backpressure.

Reset
REQ-027 When rst_n=0 at a rising edge, all state is loaded: mstatus=64'h1800 (MPP=11, MIE=0), mtvec=RESET_MTVEC with bits [1:0] cleared, and mie, mscratch, mepc, mcause, mip, mcycle and minstret are all 0.
REQ-028 Writes and counter increments are suppressed during reset; a reset asserted mid-sequence discards any pending write.
REQ-029 Outputs after reset: glb_irqen_o=0, tmr_irq_o=0, ext_irq_o=0.

Structure
REQ-030 CSR address constants, mstatus bit positions, write masks and the misa constant belong in the shared define package, reusing the existing CSR_MEPC, CSR_MCAUSE and CSR_MSTATUS macros.
REQ-031 One sub-module, csr_counter64: a 64-bit counter with increment enable and load, instantiated for mcycle and minstret.

Verification
REQ-032 Trap sequence: clint writes 0x341=0x8000_0102, then 0x342=0xB, then 0x300=0x80 on three consecutive cycles -> mepc=0x8000_0100, mcause=0xB, mstatus=0x1880, glb_irqen_o=0.
REQ-033 Collision: clint_we 0x340=0x1 and ex_we 0x340=0x2 in the same cycle -> mscratch=0x1; a separate case with ex addressing 0x305 in that cycle leaves mtvec unchanged.
REQ-034 Masking: ex writes 0x300=all-ones -> reads 0x1888; ex writes 0x304=all-ones -> reads 0x888; ex writes 0x301=0 -> misa unchanged.
REQ-035 Counters: preload mcycle=64'hFFFF_FFFF_FFFF_FFFE, then run 3 cycles -> reads 0x1; pulse instr_retire_i 5 times while writing minstret=0x10 in the third pulse cycle -> minstret=0x12.
REQ-036 Interrupts: mie=0x80, tmr_irq_i=1 -> tmr_irq_o=1 in the same cycle and mip reads 0x80 one cycle later; ext_irq_i=1 with mie[11]=0 -> ext_irq_o=0.
REQ-037 Reset mid-operation: assert rst_n=0 while clint_we_i=1 to 0x341 -> mepc=0 and mstatus=0x1800 after the edge.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
// Shared CSR definitions for the machine-mode register file: addresses,
// mstatus bit positions, write masks and the write-value legalisation helper.
package csr_regfile_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
  localparam logic [63:0] MSTATUS_FIXED = 64'h0000_0000_0000_1800;
  localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0888;
  localparam logic [63:0] ALIGN4_MASK   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_0100;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
  } csr_wr_t;

  // Value a CSR holds (and reads back) after a write of raw data.
  function automatic logic [63:0] csr_legalize(input logic [11:0] addr, input logic [63:0] data);
    logic [63:0] v;
    case (addr)
      CSR_MSTATUS:          v = (data & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MIE:              v = data & MIE_WMASK;
      CSR_MTVEC, CSR_MEPC:  v = data & ALIGN4_MASK;
      default:              v = data;
    endcase
    return v;
  endfunction

  function automatic logic csr_is_writable(input logic [11:0] addr);
    logic w;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MCYCLE, CSR_MINSTRET: w = 1'b1;
      default:                              w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping counter with synchronous load (load beats increment).
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [63:0] load_val_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // Next count: load, increment or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file with a trap-controller port (priority) and an
// execute-stage port, cycle/instret counters and interrupt gating.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter logic [63:0] HART_ID     = 64'h0,
  parameter logic [63:0] RESET_MTVEC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clint_we_i,
  input  logic [11:0] clint_addr_i,
  input  logic [63:0] clint_wdata_i,
  input  logic        ex_we_i,
  input  logic [11:0] ex_waddr_i,
  input  logic [63:0] ex_wdata_i,
  input  logic [11:0] rd_addr_i,
  output logic [63:0] rd_data_o,
  input  logic        instr_retire_i,
  input  logic        tmr_irq_i,
  input  logic        ext_irq_i,
  output logic [63:0] csr_mtvec_o,
  output logic [63:0] csr_mepc_o,
  output logic [63:0] csr_mstatus_o,
  output logic        glb_irqen_o,
  output logic        tmr_irq_o,
  output logic        ext_irq_o
);

  csr_wr_t     wr_d;
  logic [63:0] wr_val_d;
  logic [63:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip_q;
  logic [63:0] mcycle_s, minstret_s;
  logic [63:0] rd_data_d;

  // Port arbitration: a clint write discards any ex write that cycle
  always_comb begin
    wr_d = '0;
    if (clint_we_i) begin
      wr_d = '{we: 1'b1, addr: clint_addr_i, data: clint_wdata_i};
    end else if (ex_we_i) begin
      wr_d = '{we: 1'b1, addr: ex_waddr_i, data: ex_wdata_i};
    end else begin
      wr_d = '0;
    end
    wr_val_d = csr_legalize(wr_d.addr, wr_d.data);
  end

  // CSR storage; mip samples the raw interrupt lines every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_FIXED;
      mie_q      <= 64'd0;
      mtvec_q    <= RESET_MTVEC & ALIGN4_MASK;
      mscratch_q <= 64'd0;
      mepc_q     <= 64'd0;
      mcause_q   <= 64'd0;
      mip_q      <= 64'd0;
    end else begin
      if (wr_d.we) begin
        case (wr_d.addr)
          CSR_MSTATUS:  mstatus_q  <= wr_val_d;
          CSR_MIE:      mie_q      <= wr_val_d;
          CSR_MTVEC:    mtvec_q    <= wr_val_d;
          CSR_MSCRATCH: mscratch_q <= wr_val_d;
          CSR_MEPC:     mepc_q     <= wr_val_d;
          CSR_MCAUSE:   mcause_q   <= wr_val_d;
          default:      ;
        endcase
      end
      mip_q <= {52'd0, ext_irq_i, 3'd0, tmr_irq_i, 7'd0};
    end
  end

  csr_counter64 u_mcycle (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (1'b1),
    .load_i     (wr_d.we && (wr_d.addr == CSR_MCYCLE)),
    .load_val_i (wr_val_d),
    .cnt_o      (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (instr_retire_i),
    .load_i     (wr_d.we && (wr_d.addr == CSR_MINSTRET)),
    .load_val_i (wr_val_d),
    .cnt_o      (minstret_s)
  );

  // Read mux with same-cycle bypass of an uncontested ex write
  always_comb begin
    rd_data_d = 64'd0;
    case (rd_addr_i)
      CSR_MSTATUS:  rd_data_d = mstatus_q;
      CSR_MISA:     rd_data_d = MISA_VALUE;
      CSR_MIE:      rd_data_d = mie_q;
      CSR_MTVEC:    rd_data_d = mtvec_q;
      CSR_MSCRATCH: rd_data_d = mscratch_q;
      CSR_MEPC:     rd_data_d = mepc_q;
      CSR_MCAUSE:   rd_data_d = mcause_q;
      CSR_MIP:      rd_data_d = mip_q;
      CSR_MCYCLE:   rd_data_d = mcycle_s;
      CSR_MINSTRET: rd_data_d = minstret_s;
      CSR_MHARTID:  rd_data_d = HART_ID;
      default:      rd_data_d = 64'd0;
    endcase
    if (ex_we_i && !clint_we_i && (ex_waddr_i == rd_addr_i) && csr_is_writable(rd_addr_i)) begin
      rd_data_d = csr_legalize(ex_waddr_i, ex_wdata_i);
    end else begin
      rd_data_d = rd_data_d;
    end
  end

  assign rd_data_o     = rd_data_d;
  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;
  assign csr_mstatus_o = mstatus_q;
  assign glb_irqen_o   = mstatus_q[MSTATUS_MIE_BIT];
  assign tmr_irq_o     = tmr_irq_i & mie_q[MIE_MTIE_BIT];
  assign ext_irq_o     = ext_irq_i & mie_q[MIE_MEIE_BIT];

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset, trap writes, collisions, masking,
// bypass, counters, interrupts and mid-sequence reset.
module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clint_we_i;
  logic [11:0] clint_addr_i;
  logic [63:0] clint_wdata_i;
  logic        ex_we_i;
  logic [11:0] ex_waddr_i;
  logic [63:0] ex_wdata_i;
  logic [11:0] rd_addr_i;
  logic [63:0] rd_data_o;
  logic        instr_retire_i;
  logic        tmr_irq_i, ext_irq_i;
  logic [63:0] csr_mtvec_o, csr_mepc_o, csr_mstatus_o;
  logic        glb_irqen_o, tmr_irq_o, ext_irq_o;

  int checks = 0;
  int errors = 0;

  csr_regfile #(.HART_ID(64'd5), .RESET_MTVEC(64'h0000_0000_0000_1003)) dut (
    .clk(clk), .rst_n(rst_n),
    .clint_we_i(clint_we_i), .clint_addr_i(clint_addr_i), .clint_wdata_i(clint_wdata_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .instr_retire_i(instr_retire_i), .tmr_irq_i(tmr_irq_i), .ext_irq_i(ext_irq_i),
    .csr_mtvec_o(csr_mtvec_o), .csr_mepc_o(csr_mepc_o), .csr_mstatus_o(csr_mstatus_o),
    .glb_irqen_o(glb_irqen_o), .tmr_irq_o(tmr_irq_o), .ext_irq_o(ext_irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [63:0] exp);
    rd_addr_i = a;
    #1;
    chk(tag, rd_data_o, exp);
  endtask

  task automatic idle();
    clint_we_i = 1'b0;
    ex_we_i    = 1'b0;
  endtask

  task automatic clint_wr(input logic [11:0] a, input logic [63:0] d);
    clint_we_i = 1'b1; clint_addr_i = a; clint_wdata_i = d;
  endtask

  task automatic ex_wr(input logic [11:0] a, input logic [63:0] d);
    ex_we_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d;
  endtask

  initial begin
    rst_n = 1'b0; idle();
    clint_addr_i = 12'h0; clint_wdata_i = 64'h0;
    ex_waddr_i = 12'h0; ex_wdata_i = 64'h0;
    rd_addr_i = 12'h0; instr_retire_i = 1'b0;
    tmr_irq_i = 1'b0; ext_irq_i = 1'b0;
    #2;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_mstatus", csr_mstatus_o, 64'h1800);
    chk("rst_mtvec", csr_mtvec_o, 64'h1000);
    chk("rst_mepc", csr_mepc_o, 64'h0);
    chk("rst_glb", {63'd0, glb_irqen_o}, 64'd0);
    chk("rst_irqs", {62'd0, tmr_irq_o, ext_irq_o}, 64'd0);
    rd(12'hB00, "rst_mcycle", 64'h0);
    rd(12'h301, "misa", 64'h8000_0000_0000_0100);
    rd(12'hF14, "mhartid", 64'd5);

    // Trap sequence on consecutive cycles
    clint_wr(12'h341, 64'h8000_0102); tick();
    clint_wr(12'h342, 64'hB);         tick();
    clint_wr(12'h300, 64'h80);        tick();
    idle();
    chk("trap_mepc", csr_mepc_o, 64'h8000_0100);
    rd(12'h342, "trap_mcause", 64'hB);
    chk("trap_mstatus", csr_mstatus_o, 64'h1880);
    chk("trap_glb", {63'd0, glb_irqen_o}, 64'd0);

    // Collisions: clint wins, ex write discarded
    clint_wr(12'h340, 64'h1); ex_wr(12'h340, 64'h2);
    rd_addr_i = 12'h340; #1;
    chk("coll_no_bypass", rd_data_o, 64'h0);
    tick(); idle();
    rd(12'h340, "coll_mscratch", 64'h1);
    clint_wr(12'h340, 64'h3); ex_wr(12'h305, 64'hABC0); tick(); idle();
    chk("coll_mtvec", csr_mtvec_o, 64'h1000);
    rd(12'h340, "coll_mscratch2", 64'h3);

    // Masking and bypass
    ex_wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF); rd_addr_i = 12'h300; #1;
    chk("byp_mstatus", rd_data_o, 64'h1888);
    tick(); idle();
    rd(12'h300, "mask_mstatus", 64'h1888);
    chk("glb_on", {63'd0, glb_irqen_o}, 64'd1);
    ex_wr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF); tick(); idle();
    rd(12'h304, "mask_mie", 64'h888);
    ex_wr(12'h301, 64'h0); tick(); idle();
    rd(12'h301, "misa_ro", 64'h8000_0000_0000_0100);
    ex_wr(12'h305, 64'h0000_0000_0000_2223); tick(); idle();
    chk("mtvec_align", csr_mtvec_o, 64'h2220);
    ex_wr(12'h7C0, 64'h1234); tick(); idle();
    rd(12'h7C0, "unimpl", 64'h0);

    // mcycle wrap
    ex_wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE); tick(); idle();
    tick(); tick(); tick();
    rd(12'hB00, "mcycle_wrap", 64'h1);

    // minstret: write in third retire cycle has priority
    instr_retire_i = 1'b1;
    tick(); tick();
    ex_wr(12'hB02, 64'h10); tick(); idle();
    tick(); tick();
    instr_retire_i = 1'b0;
    rd(12'hB02, "minstret", 64'h12);

    // Interrupts
    ex_wr(12'h304, 64'h80); tick(); idle();
    tmr_irq_i = 1'b1; ext_irq_i = 1'b1; rd_addr_i = 12'h344; #1;
    chk("tmr_irq_o", {63'd0, tmr_irq_o}, 64'd1);
    chk("ext_irq_o", {63'd0, ext_irq_o}, 64'd0);
    chk("mip_latency", rd_data_o, 64'h0);
    tick();
    rd(12'h344, "mip", 64'h880);

    // Reset mid-operation discards the pending write
    rst_n = 1'b0; clint_wr(12'h341, 64'h1234); tick();
    idle(); rst_n = 1'b1;
    chk("midrst_mepc", csr_mepc_o, 64'h0);
    chk("midrst_mstatus", csr_mstatus_o, 64'h1800);
    chk("midrst_outs", {61'd0, glb_irqen_o, tmr_irq_o, ext_irq_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
